// File: rtl/note_seq_pkg.sv
// Shared constants for the note RAM record/playback sequencer.
package note_seq_pkg;

  localparam int unsigned NsAddrW = 6;
  localparam int unsigned NsDataW = 32;
  localparam int unsigned NsDepth = 2 ** NsAddrW;

  // State codes double as the HEX debug display value.
  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StRec       = 3'd1;
  localparam logic [2:0] StPlayWait  = 3'd2;
  localparam logic [2:0] StPlayFetch = 3'd3;
  localparam logic [2:0] StPlayHold  = 3'd4;

endpackage

// File: rtl/note_seq_accum.sv
// Chord OR-accumulator; word_o is the value a tick in this cycle would capture.
module note_seq_accum
  import note_seq_pkg::*;
#(
  parameter int unsigned DATA_W = NsDataW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              cap_i,
  input  logic [DATA_W-1:0] note_i,
  output logic [DATA_W-1:0] word_o
);

  logic [DATA_W-1:0] acc_d, acc_q;

  assign word_o = acc_q | note_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i || cap_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = word_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/note_seq_ctrl.sv
// Record/playback sequencer for the single-port note RAM.
// Define NOTE_SEQ_LOOP_EN to make playback wrap to the first word instead of stopping.
module note_seq_ctrl
  import note_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = NsAddrW,
  parameter int unsigned DATA_W = NsDataW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic              cmd_record_i,
  input  logic              cmd_play_i,
  input  logic              cmd_stop_i,
  input  logic [DATA_W-1:0] note_in_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] note_out_o,
  output logic              note_valid_o,
  input  logic              audio_ready_i,
  output logic [ADDR_W:0]   rec_len_o,
  output logic              full_o,
  output logic              overrun_o,
  output logic [2:0]        state_o
);

  localparam logic [ADDR_W-1:0] PtrOne = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LenOne = (ADDR_W + 1)'(1);
  localparam logic [1:0]        LatEnd = 2'(RD_LAT);

  logic [2:0]        state_d, state_q;
  logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [ADDR_W:0]   rec_len_d, rec_len_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic              mem_we_d, mem_we_q;
  logic [DATA_W-1:0] note_out_d, note_out_q;
  logic              note_valid_d, note_valid_q;
  logic              full_d, full_q;
  logic              overrun_d, overrun_q;
  logic [1:0]        lat_d, lat_q;

  logic              acc_clr, acc_en, acc_cap;
  logic [DATA_W-1:0] acc_word;

  note_seq_accum #(
    .DATA_W(DATA_W)
  ) u_accum (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (acc_clr),
    .en_i   (acc_en),
    .cap_i  (acc_cap),
    .note_i (note_in_i),
    .word_o (acc_word)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rec_len_d    = rec_len_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    note_out_d   = note_out_q;
    note_valid_d = note_valid_q;
    full_d       = full_q;
    overrun_d    = overrun_q;
    lat_d        = lat_q;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
    acc_cap      = 1'b0;

    if (cmd_stop_i) begin
      state_d      = StIdle;
      note_valid_d = 1'b0;
      note_out_d   = '0;
      acc_clr      = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_record_i) begin
            wr_ptr_d  = '0;
            rec_len_d = '0;
            full_d    = 1'b0;
            acc_clr   = 1'b1;
            state_d   = StRec;
          end else if (cmd_play_i && (rec_len_q != '0)) begin
            rd_ptr_d  = '0;
            overrun_d = 1'b0;
            state_d   = StPlayWait;
          end
        end
        StRec: begin
          acc_en = 1'b1;
          if (tick_i) begin
            acc_cap     = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_ptr_q;
            mem_wdata_d = acc_word;
            wr_ptr_d    = wr_ptr_q + PtrOne;
            rec_len_d   = {1'b0, wr_ptr_q} + LenOne;
            if (&wr_ptr_q) begin
              full_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
        StPlayWait: begin
          if (tick_i) begin
            mem_addr_d = rd_ptr_q;
            lat_d      = '0;
            state_d    = StPlayFetch;
          end
        end
        StPlayFetch: begin
          if (tick_i) begin
            overrun_d = 1'b1;
          end
          // Address is on the bus in the first fetch cycle; data trails it by RD_LAT cycles.
          if (lat_q == LatEnd) begin
            note_out_d   = mem_rdata_i;
            note_valid_d = 1'b1;
            state_d      = StPlayHold;
          end else begin
            lat_d = lat_q + 2'd1;
          end
        end
        StPlayHold: begin
          if (tick_i) begin
            overrun_d = 1'b1;
          end
          if (note_valid_q && audio_ready_i) begin
            note_valid_d = 1'b0;
            if ({1'b0, rd_ptr_q} == rec_len_q - LenOne) begin
`ifdef NOTE_SEQ_LOOP_EN
              rd_ptr_d = '0;
              state_d  = StPlayWait;
`else
              note_out_d = '0;
              state_d    = StIdle;
`endif
            end else begin
              rd_ptr_d = rd_ptr_q + PtrOne;
              state_d  = StPlayWait;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rec_len_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      note_out_q   <= '0;
      note_valid_q <= 1'b0;
      full_q       <= 1'b0;
      overrun_q    <= 1'b0;
      lat_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rec_len_q    <= rec_len_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      note_out_q   <= note_out_d;
      note_valid_q <= note_valid_d;
      full_q       <= full_d;
      overrun_q    <= overrun_d;
      lat_q        <= lat_d;
    end
  end

  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_we_o     = mem_we_q;
  assign note_out_o   = note_out_q;
  assign note_valid_o = note_valid_q;
  assign rec_len_o    = rec_len_q;
  assign full_o       = full_q;
  assign overrun_o    = overrun_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Bench for note_seq_ctrl: behavioural RAM, write/note scoreboards, vector table.
module tb_note_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick, cmd_record, cmd_play, cmd_stop, audio_ready;
  logic [31:0] note_in, mem_wdata, mem_rdata, note_out;
  logic [5:0]  mem_addr;
  logic        mem_we, note_valid, full, overrun;
  logic [6:0]  rec_len;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;
  int xfer_cnt = 0;

  logic [37:0] wq[$];
  logic [31:0] nq[$];
  logic [31:0] exp_mem[64];
  logic [31:0] ram[64];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] w;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  note_seq_ctrl u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tick_i        (tick),
    .cmd_record_i  (cmd_record),
    .cmd_play_i    (cmd_play),
    .cmd_stop_i    (cmd_stop),
    .note_in_i     (note_in),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_we_o      (mem_we),
    .mem_rdata_i   (mem_rdata),
    .note_out_o    (note_out),
    .note_valid_o  (note_valid),
    .audio_ready_i (audio_ready),
    .rec_len_o     (rec_len),
    .full_o        (full),
    .overrun_o     (overrun),
    .state_o       (state)
  );

  // One-cycle synchronous-read RAM.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (wq.size() == 0) begin
        chk("unexpected_we", 64'd1, 64'd0);
      end else begin
        logic [37:0] e;
        e = wq.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e[37:32]));
        chk("wr_data", 64'(mem_wdata), 64'(e[31:0]));
      end
    end
    if (note_valid && audio_ready) begin
      xfer_cnt++;
      if (nq.size() == 0) chk("unexpected_note", 64'd1, 64'd0);
      else chk("note_out", 64'(note_out), 64'(nq.pop_front()));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xfer(input int target, input string name);
    for (int i = 0; i < 12; i++) begin
      if (xfer_cnt >= target) break;
      cyc();
    end
    chk(name, 64'(xfer_cnt >= target), 64'd1);
  endtask

  task automatic play_tick(input int idx);
    tick = 1'b1;
    nq.push_back(exp_mem[idx]);
    cyc();
    tick = 1'b0;
  endtask

  initial begin
    vecs[0] = '{a: 32'h0000_0001, b: 32'h0000_0000, w: 32'h0000_0001};
    vecs[1] = '{a: 32'h0000_0040, b: 32'h0000_0000, w: 32'h0000_0040};
    vecs[2] = '{a: 32'h0000_2000, b: 32'h0000_0000, w: 32'h0000_2000};
    vecs[3] = '{a: 32'h0000_0001, b: 32'h0000_0080, w: 32'h0000_0081};

    rst_n = 1'b0; tick = 0; cmd_record = 0; cmd_play = 0; cmd_stop = 0;
    audio_ready = 0; note_in = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_rec_len", 64'(rec_len), 64'd0);
    chk("rst_outs", 64'({mem_we, note_valid, full, overrun}), 64'd0);
    chk("rst_note_out", 64'(note_out), 64'd0);

    // Record the vector table, one word per tick window.
    cmd_record = 1; cyc(); cmd_record = 0;
    chk("rec_state", 64'(state), 64'd1);
    for (int i = 0; i < 4; i++) begin
      note_in = vecs[i].a;
      cyc();
      note_in = vecs[i].b;
      tick = 1;
      exp_mem[i] = vecs[i].w;
      wq.push_back({6'(i), vecs[i].w});
      cyc();
      tick = 0; note_in = '0;
      cyc();
      chk("rec_len_step", 64'(rec_len), 64'(i + 1));
    end
    // Partial window discarded by stop.
    note_in = 32'hFFFF; cyc(); note_in = '0;
    cmd_stop = 1; cyc(); cmd_stop = 0;
    cyc();
    chk("stop_state", 64'(state), 64'd0);
    chk("stop_rec_len", 64'(rec_len), 64'd4);

    // Playback with audio always ready.
    audio_ready = 1;
    cmd_play = 1; cyc(); cmd_play = 0;
    chk("play_state", 64'(state), 64'd2);
    for (int i = 0; i < 4; i++) begin
      play_tick(i);
      wait_xfer(i + 1, "play_xfer");
      repeat (2) cyc();
    end
    chk("play_overrun", 64'(overrun), 64'd0);
`ifdef NOTE_SEQ_LOOP_EN
    chk("loop_state", 64'(state), 64'd2);
    play_tick(0);
    wait_xfer(5, "loop_xfer");
    cmd_stop = 1; cyc(); cmd_stop = 0;
`else
    chk("end_state", 64'(state), 64'd0);
`endif
    chk("end_note_out", 64'(note_out), 64'd0);
    chk("end_valid", 64'(note_valid), 64'd0);

    // Overrun: tick arrives while the note is still held.
    audio_ready = 0;
    cmd_play = 1; cyc(); cmd_play = 0;
    play_tick(0);
    for (int i = 0; i < 10; i++) begin
      if (note_valid) break;
      cyc();
    end
    chk("hold_valid", 64'(note_valid), 64'd1);
    tick = 1; cyc(); tick = 0;
    cyc();
    chk("ovr_flag", 64'(overrun), 64'd1);
    chk("ovr_valid", 64'(note_valid), 64'd1);
    chk("ovr_state", 64'(state), 64'd4);
    audio_ready = 1;
    wait_xfer(xfer_cnt + 1, "ovr_xfer0");
    chk("ovr_wait_state", 64'(state), 64'd2);
    play_tick(1);
    wait_xfer(xfer_cnt + 1, "ovr_xfer1");
    cmd_stop = 1; cyc(); cmd_stop = 0;
    chk("ovr_stop_state", 64'(state), 64'd0);
    chk("ovr_stop_len", 64'(rec_len), 64'd4);
    audio_ready = 0;

    // Command priority.
    cmd_stop = 1; cmd_record = 1; cyc(); cmd_stop = 0; cmd_record = 0;
    chk("prio_stop_state", 64'(state), 64'd0);
    chk("prio_stop_len", 64'(rec_len), 64'd4);
    cmd_record = 1; cmd_play = 1; cyc(); cmd_record = 0; cmd_play = 0;
    chk("prio_rec_state", 64'(state), 64'd1);
    chk("prio_rec_len", 64'(rec_len), 64'd0);

    // Fill all 64 words.
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = $urandom;
      exp_mem[i] = w;
      note_in = w;
      tick = 1;
      wq.push_back({6'(i), w});
      cyc();
      tick = 0; note_in = '0;
      cyc();
    end
    cyc();
    chk("full_flag", 64'(full), 64'd1);
    chk("full_state", 64'(state), 64'd0);
    chk("full_rec_len", 64'(rec_len), 64'd64);
    tick = 1; cyc(); tick = 0;
    repeat (2) cyc();
    chk("full_wq_empty", 64'(wq.size()), 64'd0);
    cmd_record = 1; cyc(); cmd_record = 0;
    chk("rerec_full", 64'(full), 64'd0);
    chk("rerec_len", 64'(rec_len), 64'd0);

    // Asynchronous reset mid-recording, with a tick pending.
    note_in = 32'h55; cyc();
    tick = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_state", 64'(state), 64'd0);
    chk("mrst_outs", 64'({mem_we, note_valid, full, overrun}), 64'd0);
    chk("mrst_data", 64'({mem_addr, mem_wdata, note_out}), 64'd0);
    chk("mrst_len", 64'(rec_len), 64'd0);
    tick = 0; note_in = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    cmd_play = 1; cyc(); cmd_play = 0;
    chk("play_empty_state", 64'(state), 64'd0);
    // Accumulator must have been cleared by reset.
    cmd_record = 1; cyc(); cmd_record = 0;
    note_in = 32'h2; tick = 1;
    wq.push_back({6'd0, 32'h2});
    cyc();
    tick = 0; note_in = '0;
    repeat (3) cyc();
    chk("post_rst_len", 64'(rec_len), 64'd1);
    chk("wq_drained", 64'(wq.size()), 64'd0);
    chk("nq_drained", 64'(nq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
